// File: rtl/mac32_arbiter.sv
// rtl/mac32_arbiter.sv - NREQ-way arbiter issuing MAC ops in order with a tag FIFO for responses
// Define MAC32_ARB_FIXED_PRIO_EN for fixed-priority (lowest index wins) instead of round-robin.
module mac32_arbiter #(
    parameter int PARM_XLEN    = 32,
    parameter int NREQ         = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ*PARM_XLEN-1:0] req_a_i,
    input  logic [NREQ*PARM_XLEN-1:0] req_b_i,
    input  logic [NREQ*PARM_XLEN-1:0] req_c_i,
    output logic [PARM_XLEN-1:0]      mac_a_o,
    output logic [PARM_XLEN-1:0]      mac_b_o,
    output logic [PARM_XLEN-1:0]      mac_c_o,
    output logic                      mac_valid_o,
    input  logic                      mac_valid_i,
    input  logic [PARM_XLEN-1:0]      mac_result_i,
    output logic [NREQ-1:0]           rsp_valid_o,
    output logic [PARM_XLEN-1:0]      rsp_data_o,
    output logic                      busy_o,
    output logic                      err_o
);
    localparam int TAG_W = $clog2(NREQ);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {OCC_EMPTY, OCC_ACTIVE, OCC_FULL} occ_e;

    logic [TAG_W-1:0]     tag_mem_q [MAX_INFLIGHT];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    occ_e                 occ_q, occ_d;
    logic [PARM_XLEN-1:0] mac_a_q, mac_b_q, mac_c_q, rsp_data_q;
    logic [NREQ-1:0]      rsp_valid_q;
    logic                 mac_valid_q, err_q;
    logic                 found, hs, pop;
    logic [TAG_W-1:0]     win_idx, idx;
    int                   s;

`ifdef MAC32_ARB_FIXED_PRIO_EN
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        s       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            s   = i;
            idx = TAG_W'(s);
            if (req_valid_i[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end
`else
    logic [TAG_W-1:0] ptr_q;

    // Descending scan so the requester closest to ptr_q (smallest offset) wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        s       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            s = int'(ptr_q) + i;
            if (s >= NREQ) s = s - NREQ;
            idx = TAG_W'(s);
            if (req_valid_i[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (hs) begin
            ptr_q <= (win_idx == TAG_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    // Full is taken from registered occupancy; a same-cycle pop does not open a slot.
    assign hs  = found && (occ_q != OCC_FULL) && !rst;
    assign pop = mac_valid_i && (occ_q != OCC_EMPTY);

    always_comb begin
        req_ready_o = '0;
        if (hs) req_ready_o[win_idx] = 1'b1;
    end

    always_comb begin
        count_d = count_q;
        if (hs && !pop)      count_d = count_q + 1'b1;
        else if (!hs && pop) count_d = count_q - 1'b1;
        if (count_d == '0)                           occ_d = OCC_EMPTY;
        else if (count_d == CNT_W'(MAX_INFLIGHT))    occ_d = OCC_FULL;
        else                                         occ_d = OCC_ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (hs) tag_mem_q[wr_ptr_q] <= win_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            mac_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            occ_q       <= OCC_EMPTY;
        end else begin
            mac_valid_q <= hs;
            rsp_valid_q <= '0;
            count_q     <= count_d;
            occ_q       <= occ_d;
            if (hs) begin
                mac_a_q  <= req_a_i[win_idx*PARM_XLEN +: PARM_XLEN];
                mac_b_q  <= req_b_i[win_idx*PARM_XLEN +: PARM_XLEN];
                mac_c_q  <= req_c_i[win_idx*PARM_XLEN +: PARM_XLEN];
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rsp_valid_q[tag_mem_q[rd_ptr_q]] <= 1'b1;
                rsp_data_q <= mac_result_i;
                rd_ptr_q   <= (rd_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (mac_valid_i && (occ_q == OCC_EMPTY)) err_q <= 1'b1;
        end
    end

    assign mac_a_o     = mac_a_q;
    assign mac_b_o     = mac_b_q;
    assign mac_c_o     = mac_c_q;
    assign mac_valid_o = mac_valid_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign err_o       = err_q;
    assign busy_o      = (count_q != '0);
endmodule

// File: tb/tb_mac32_arbiter.sv
// tb/tb_mac32_arbiter.sv - directed self-checking bench for mac32_arbiter
module tb_mac32_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b, req_c;
    logic [31:0]  mac_a, mac_b, mac_c, mac_result, rsp_data;
    logic         mac_valid_o, mac_valid_i, busy, err;
    logic [3:0]   rsp_valid;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    mac32_arbiter #(.PARM_XLEN(32), .NREQ(4), .MAX_INFLIGHT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
        .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_c_o(mac_c),
        .mac_valid_o(mac_valid_o), .mac_valid_i(mac_valid_i), .mac_result_i(mac_result),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .busy_o(busy), .err_o(err)
    );

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
        mac_valid_i = 1'b0; mac_result = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111; req_a = '0; req_b = '0; req_c = '0;
        mac_valid_i = 1'b0; mac_result = '0;
        @(negedge clk);
        #1;
        checks++;
        if ({mac_valid_o, rsp_valid, rsp_data, mac_a, mac_b, mac_c, err, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs got mv=%b rv=%b rd=%h a=%h err=%b busy=%b exp all 0",
                               mac_valid_o, rsp_valid, rsp_data, mac_a, err, busy);
        end
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        do_reset();
        req_valid = 4'b0001;
        req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000; req_c[31:0] = 32'h40400000;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({mac_valid_o, mac_a, mac_b, mac_c, busy} !== {1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1}) begin
            errors++; $display("FAIL single_issue got v=%b a=%h b=%h c=%h busy=%b exp 1 3F800000 40000000 40400000 1",
                               mac_valid_o, mac_a, mac_b, mac_c, busy);
        end
        @(negedge clk);
        checks++;
        if (mac_valid_o !== 1'b0 || mac_a !== 32'h3F800000) begin
            errors++; $display("FAIL single_hold got v=%b a=%h exp 0 3F800000", mac_valid_o, mac_a);
        end
        @(negedge clk);
        @(negedge clk);
        mac_valid_i = 1'b1; mac_result = 32'h40E00000;
        @(negedge clk);
        mac_valid_i = 1'b0; mac_result = 32'h0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'h40E00000 || busy !== 1'b0) begin
            errors++; $display("FAIL single_rsp got rv=%b rd=%h busy=%b exp 0001 40E00000 0", rsp_valid, rsp_data, busy);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000 || err !== 1'b0) begin
            errors++; $display("FAIL single_rsp_once got rv=%b err=%b exp 0000 0", rsp_valid, err);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_g [5];
`ifdef MAC32_ARB_FIXED_PRIO_EN
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        do_reset();
        req_valid = 4'b1111;
        mac_result = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                mac_valid_i = 1'b1;
            end
            #1;
            checks++;
            if (req_ready !== exp_g[i]) begin
                errors++; $display("FAIL contention_grant%0d got %b exp %b", i, req_ready, exp_g[i]);
            end
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        mac_valid_i = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL contention_end got err=%b busy=%b exp 0 0", err, busy);
        end
    endtask

    task automatic test_full();
        int issues = 0;
        do_reset();
        req_valid = 4'b0001;
        req_a[31:0] = 32'h00000011;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (mac_valid_o) issues++;
            checks++;
            if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_grant%0d got %b exp 0001", i, req_ready); end
        end
        @(negedge clk);
        #1;
        if (mac_valid_o) issues++;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
            errors++; $display("FAIL full_blocked got ready=%b busy=%b exp 0000 1", req_ready, busy);
        end
        @(negedge clk);
        mac_valid_i = 1'b1; mac_result = 32'hCAFEF00D;
        #1;
        if (mac_valid_o) issues++;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_no_bypass got %b exp 0000", req_ready); end
        checks++;
        if (issues !== 4) begin errors++; $display("FAIL full_issue_count got %0d exp 4", issues); end
        @(negedge clk);
        mac_valid_i = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || rsp_valid !== 4'b0001 || rsp_data !== 32'hCAFEF00D) begin
            errors++; $display("FAIL full_release got ready=%b rv=%b rd=%h exp 0001 0001 CAFEF00D",
                               req_ready, rsp_valid, rsp_data);
        end
        req_valid = '0;
    endtask

    task automatic test_ordering();
        do_reset();
        req_valid = 4'b0100;
        req_a[95:64] = 32'h22222222;
        req_a[63:32] = 32'h11111111;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL order_grant2 got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010 || mac_a !== 32'h22222222) begin
            errors++; $display("FAIL order_grant1 got %b a=%h exp 0010 22222222", req_ready, mac_a);
        end
        @(negedge clk);
        req_valid = '0;
        mac_valid_i = 1'b1; mac_result = 32'h40A00000;
        #1;
        checks++;
        if (mac_a !== 32'h11111111 || mac_valid_o !== 1'b1) begin
            errors++; $display("FAIL order_issue1 got a=%h v=%b exp 11111111 1", mac_a, mac_valid_o);
        end
        @(negedge clk);
        mac_result = 32'h41000000;
        #1;
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 32'h40A00000) begin
            errors++; $display("FAIL order_rsp_first got rv=%b rd=%h exp 0100 40A00000", rsp_valid, rsp_data);
        end
        @(negedge clk);
        mac_valid_i = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'h41000000 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL order_rsp_second got rv=%b rd=%h busy=%b err=%b exp 0010 41000000 0 0",
                               rsp_valid, rsp_data, busy, err);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        mac_valid_i = 1'b1; mac_result = 32'hDEADBEEF;
        @(negedge clk);
        mac_valid_i = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || err !== 1'b1) begin
            errors++; $display("FAIL spurious_drop got rv=%b err=%b exp 0000 1", rsp_valid, err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL spurious_sticky got %b exp 1", err); end
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL spurious_cleared got %b exp 0", err); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 4'b0001;
        req_a[31:0] = 32'hAAAA5555;
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || mac_valid_o !== 1'b1) begin
            errors++; $display("FAIL midflight_pre got busy=%b v=%b exp 1 1", busy, mac_valid_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mac_valid_o, rsp_valid, rsp_data, mac_a, mac_b, mac_c, err, busy, req_ready} !== '0) begin
            errors++; $display("FAIL midflight_async got v=%b a=%h busy=%b ready=%b exp all 0",
                               mac_valid_o, mac_a, busy, req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        mac_valid_i = 1'b1; mac_result = 32'h77777777;
        @(negedge clk);
        mac_valid_i = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || err !== 1'b1) begin
            errors++; $display("FAIL midflight_stale got rv=%b err=%b exp 0000 1", rsp_valid, err);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_full();
        test_ordering();
        test_spurious();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
